// File: rtl/mx_pkg.sv
// mx_pkg: BF16 field helpers, E8M0 constants and converter FSM states.
package mx_pkg;
  localparam int BF16_BIAS = 127;
  localparam logic [7:0] E8M0_NAN = 8'hFF;
  typedef enum logic [1:0] {COLLECT, QUANT, OUTPUT} state_t;
  function automatic logic bf16_sign(input logic [15:0] x);
    return x[15];
  endfunction
  function automatic logic [7:0] bf16_exp(input logic [15:0] x);
    return x[14:7];
  endfunction
  function automatic logic [6:0] bf16_man(input logic [15:0] x);
    return x[6:0];
  endfunction
  function automatic int emax_elem(input int ew);
    return 1 << (ew - 1);
  endfunction
endpackage

// File: rtl/conv_bf16tomx_stream_if.sv
// conv_bf16tomx_stream_if: BF16 beat input and MX block output handshakes.
interface conv_bf16tomx_stream_if #(
  parameter int lanes = 8,
  parameter int k = 32,
  parameter int bit_width = 6
);
  logic i_valid;
  logic o_ready;
  logic [16*lanes-1:0] i_bf16_vec;
  logic o_valid;
  logic i_ready;
  logic [bit_width*k-1:0] o_mx_vec;
  logic [7:0] o_mx_exp;
  modport slave(input i_valid, i_bf16_vec, i_ready, output o_ready, o_valid, o_mx_vec, o_mx_exp);
  modport master(output i_valid, i_bf16_vec, i_ready, input o_ready, o_valid, o_mx_vec, o_mx_exp);
endinterface

// File: rtl/conv_bf16tomx_elem.sv
// conv_bf16tomx_elem: quantise one BF16 value against a shared exponent, RNE, saturating.
module conv_bf16tomx_elem import mx_pkg::*; #(
  parameter int exp_width = 3,
  parameter int man_width = 2,
  localparam int bit_width = 1 + exp_width + man_width
) (
  input  logic [15:0]          i_bf16,
  input  logic [7:0]           i_shared,
  output logic [bit_width-1:0] o_code
);
  localparam int bias = emax_elem(exp_width) - 1;
  localparam logic signed [10:0] min_u = 11'(1 - bias);
  localparam logic signed [10:0] max_s = 11'((1 << (bit_width - 1)) - 1);
  localparam logic [bit_width-2:0] max_mag = '1;
  logic signed [10:0] u, u_eff, shift_full, mag;
  logic [3:0] shift;
  logic [8:0] sig, q, gbit;
  logic rnd;
  logic [bit_width-2:0] mag_c;
  // subnormal results widen the shift; exponent base and rounded significand add so carries propagate
  always_comb begin
    u = $signed({3'b0, bf16_exp(i_bf16)}) - $signed({3'b0, i_shared});
    u_eff = u < min_u ? min_u : u;
    shift_full = u_eff - u + 11'(7 - man_width);
    shift = shift_full > 11'sd9 ? 4'd9 : shift_full[3:0];
    sig = {2'b01, bf16_man(i_bf16)};
    q = sig >> shift;
    gbit = 9'd1 << (shift - 4'd1);
    rnd = (|(sig & gbit)) & ((|(sig & (gbit - 9'd1))) | q[0]);
    mag = ((u_eff + 11'(bias - 1)) <<< man_width) + $signed({2'b0, q}) + $signed({10'b0, rnd});
    mag_c = bf16_exp(i_bf16) == 8'd0 ? '0 : mag > max_s ? max_mag : mag[bit_width-2:0];
    o_code = {bf16_sign(i_bf16), mag_c};
  end
endmodule

// File: rtl/conv_bf16tomx_stream.sv
// conv_bf16tomx_stream: collects k BF16 values over k/lanes beats and emits one MX block.
module conv_bf16tomx_stream import mx_pkg::*; #(
  parameter int exp_width = 3,
  parameter int man_width = 2,
  parameter int k = 32,
  parameter int lanes = 8,
  localparam int bit_width = 1 + exp_width + man_width
) (
  input logic i_clk,
  input logic i_rst_n,
  conv_bf16tomx_stream_if.slave io
);
  localparam int beats = k / lanes;
  localparam int cw = beats > 1 ? $clog2(beats) : 1;
  localparam logic [7:0] emax = 8'(emax_elem(exp_width));
  state_t state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [7:0] max_q, max_d, beat_max, mx_exp_q, mx_exp_d, shared;
  logic nan_q, nan_d, beat_nan, ready_q, ready_d, valid_q, valid_d, acc, last;
  logic [16*k-1:0] buf_q, buf_d;
  logic [bit_width*k-1:0] vec_q, vec_d, codes;
  always_comb begin
    beat_max = '0;
    beat_nan = 1'b0;
    for (int i = 0; i < lanes; i++) begin
      beat_max = bf16_exp(io.i_bf16_vec[16*i +: 16]) > beat_max ? bf16_exp(io.i_bf16_vec[16*i +: 16]) : beat_max;
      beat_nan = beat_nan | (bf16_exp(io.i_bf16_vec[16*i +: 16]) == E8M0_NAN);
    end
  end
  assign shared = nan_q ? E8M0_NAN : max_q > emax ? max_q - emax : 8'd0;
  for (genvar i = 0; i < k; i++) begin : g_elem
    conv_bf16tomx_elem #(.exp_width(exp_width), .man_width(man_width)) u_elem (
      .i_bf16(buf_q[16*i +: 16]),
      .i_shared(shared),
      .o_code(codes[bit_width*i +: bit_width])
    );
  end
  assign acc = state_q == COLLECT && io.i_valid;
  assign last = cnt_q == cw'(beats - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    max_d = max_q;
    nan_d = nan_q;
    buf_d = buf_q;
    vec_d = vec_q;
    mx_exp_d = mx_exp_q;
    if (acc) begin
      buf_d[16*lanes*cnt_q +: 16*lanes] = io.i_bf16_vec;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      max_d = beat_max > max_q ? beat_max : max_q;
      nan_d = nan_q | beat_nan;
      state_d = last ? QUANT : COLLECT;
    end
    if (state_q == QUANT) begin
      vec_d = nan_q ? '0 : codes;
      mx_exp_d = shared;
      state_d = OUTPUT;
    end
    // leaving OUTPUT clears the block statistics so the next block starts clean
    if (state_q == OUTPUT && io.i_ready) begin
      max_d = '0;
      nan_d = 1'b0;
      state_d = COLLECT;
    end
    ready_d = state_d == COLLECT;
    valid_d = state_d == OUTPUT;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      max_q <= '0;
      nan_q <= 1'b0;
      buf_q <= '0;
      vec_q <= '0;
      mx_exp_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
      nan_q <= nan_d;
      buf_q <= buf_d;
      vec_q <= vec_d;
      mx_exp_q <= mx_exp_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end
  assign io.o_ready = ready_q;
  assign io.o_valid = valid_q;
  assign io.o_mx_vec = vec_q;
  assign io.o_mx_exp = mx_exp_q;
endmodule

// File: tb/tb_conv_bf16tomx_stream.sv
// tb_conv_bf16tomx_stream: directed vectors for E3M2, k=32, lanes=8 with hand-derived results.
module tb_conv_bf16tomx_stream;
  logic clk, rst_n;
  int n_chk = 0;
  int n_err = 0;
  logic [16*32-1:0] blk;
  logic [191:0] v;
  conv_bf16tomx_stream_if #(.lanes(8), .k(32), .bit_width(6)) io ();
  conv_bf16tomx_stream #(.exp_width(3), .man_width(2), .k(32), .lanes(8)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .io(io)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic fill(input logic [15:0] x);
    for (int i = 0; i < 32; i++) blk[16*i +: 16] = x;
  endtask
  task automatic send_beat(input logic [127:0] d);
    int n;
    n = 0;
    @(negedge clk);
    io.i_valid = 1'b1;
    io.i_bf16_vec = d;
    while (!io.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("beat_timeout", io.o_ready, 1);
    @(posedge clk);
  endtask
  task automatic send_block();
    for (int b = 0; b < 4; b++) send_beat(blk[128*b +: 128]);
    #1 io.i_valid = 1'b0;
  endtask
  task automatic expect_block(input string tag, input logic [7:0] e, input logic [191:0] vec);
    @(negedge clk);
    check({tag, "_quant"}, io.o_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, io.o_valid, 1);
    check({tag, "_exp"}, io.o_mx_exp, e);
    check({tag, "_vec"}, io.o_mx_vec, vec);
    if (io.i_ready) begin
      @(negedge clk);
      check({tag, "_done"}, {io.o_valid, io.o_ready}, 2'b01);
    end
  endtask
  initial begin
    int nv;
    io.i_valid = 1'b0;
    io.i_bf16_vec = '0;
    io.i_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", io.o_ready, 1);
    check("rst_valid", io.o_valid, 0);
    check("rst_exp", io.o_mx_exp, 0);
    check("rst_vec", io.o_mx_vec, 0);
    rst_n = 1'b1;
    fill(16'h3F80);
    send_block();
    expect_block("ones", 8'h7B, {32{6'h1C}});
    fill(16'h3F80);
    blk[16 +: 16] = 16'h3F90;
    blk[32 +: 16] = 16'h3FA0;
    v = {32{6'h1C}};
    v[12 +: 6] = 6'h1D;
    send_block();
    expect_block("round", 8'h7B, v);
    fill(16'h3F80);
    blk[16*29 +: 16] = 16'h7FC0;
    send_block();
    expect_block("nan", 8'hFF, 0);
    fill(16'h0000);
    blk[16*3 +: 16] = 16'h0040;
    blk[16*30 +: 16] = 16'h007F;
    send_block();
    expect_block("zero", 8'h00, 0);
    fill(16'h0000);
    blk[0 +: 16] = 16'h4380;
    blk[16 +: 16] = 16'h3F80;
    blk[32 +: 16] = 16'hBF80;
    blk[48 +: 16] = 16'h3F00;
    blk[64 +: 16] = 16'hBF00;
    blk[80 +: 16] = 16'h3F40;
    v = '0;
    v[0 +: 6] = 6'h1C;
    v[6 +: 6] = 6'h01;
    v[12 +: 6] = 6'h21;
    v[18 +: 6] = 6'h00;
    v[24 +: 6] = 6'h20;
    v[30 +: 6] = 6'h01;
    send_block();
    expect_block("scale", 8'h83, v);
    fill(16'h3FF0);
    blk[16*7 +: 16] = 16'hBFF0;
    v = {32{6'h1F}};
    v[42 +: 6] = 6'h3F;
    send_block();
    expect_block("sat", 8'h7B, v);
    io.i_ready = 1'b0;
    fill(16'h3F80);
    send_block();
    expect_block("bp", 8'h7B, {32{6'h1C}});
    io.i_valid = 1'b1;
    io.i_bf16_vec = {8{16'h4000}};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_ready", io.o_ready, 0);
      check("bp_hold", io.o_valid, 1);
      check("bp_exp", io.o_mx_exp, 8'h7B);
      check("bp_vec", io.o_mx_vec, {32{6'h1C}});
    end
    io.i_valid = 1'b0;
    io.i_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {io.o_valid, io.o_ready}, 2'b01);
    fill(16'hBF80);
    send_block();
    expect_block("after_bp", 8'h7B, {32{6'h3C}});
    io.i_ready = 1'b0;
    fill(16'h3F80);
    send_block();
    expect_block("arst", 8'h7B, {32{6'h1C}});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", io.o_valid, 0);
    check("arst_ready", io.o_ready, 1);
    check("arst_exp", io.o_mx_exp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    io.i_ready = 1'b1;
    fill(16'h4000);
    send_beat(blk[0 +: 128]);
    send_beat(blk[128 +: 128]);
    #1 io.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill(16'hBF80);
    send_block();
    expect_block("midrst", 8'h7B, {32{6'h3C}});
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      nv += int'(io.o_valid);
    end
    check("one_block", nv, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
